// File: rtl/ysyx_22040125_pkg.sv
// Shared constants for the writeback scheduler: register-file geometry and
// the fixed requester slot assignment used by the round-robin arbiter.
package ysyx_22040125_pkg;

    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NREG = 32;

    // Requester slot indices on the writeback arbiter
    localparam int REQ_ALU = 0;
    localparam int REQ_MDU = 1;
    localparam int REQ_LSU = 2;

endpackage

// File: rtl/ysyx_22040125_rr_arb.sv
// N-wide round-robin arbiter: searches upward from ptr_i (mod N) and grants
// the first asserted request. Purely combinational; the pointer lives in the
// caller so it can decide when a grant actually advances it.
module ysyx_22040125_rr_arb #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // First valid request at or after the pointer wins
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ysyx_22040125_wb_sched.sv
// Writeback scheduler: arbitrates NREQ result producers onto the single
// register-file write port (registered, one cycle latency) and keeps a busy
// scoreboard that stalls issue on RAW/WAW hazards. The register file forwards
// the data being written, so a register retiring this cycle does not stall.
module ysyx_22040125_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = ysyx_22040125_pkg::XLEN,
    parameter int AW   = ysyx_22040125_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 wb_en,
    output logic [AW-1:0]        wb_addr,
    output logic [XLEN-1:0]      wb_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        iss_rs1,
    input  logic [AW-1:0]        iss_rs2,
    output logic                 iss_hazard,
    output logic [31:0]          busy_vec
);

    import ysyx_22040125_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wb_en_q, wb_en_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            iss_go;

    // A source is busy only if no write to it retires this cycle
    function automatic logic src_busy(input logic [NREG-1:0] busy,
                                      input logic            en,
                                      input logic [AW-1:0]   addr,
                                      input logic [AW-1:0]   r);
        return busy[r] & ~(en & (addr == r));
    endfunction

    ysyx_22040125_rr_arb #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Ready is the one-hot grant, suppressed while reset is held
    always_comb begin
        req_ready = rst_n ? gnt : '0;
        sel_rd    = req_rd[int'(gnt_idx)*AW +: AW];
        sel_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];
    end

    // Hazard detection and next-state for pointer, write port and scoreboard
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        busy_d    = busy_q;

        iss_hazard = iss_valid &
                     (src_busy(busy_q, wb_en_q, wb_addr_q, iss_rs1) |
                      src_busy(busy_q, wb_en_q, wb_addr_q, iss_rs2) |
                      src_busy(busy_q, wb_en_q, wb_addr_q, iss_rd));
        iss_go = iss_valid & ~iss_hazard;

        if (gnt_any) begin
            rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : PW'(int'(gnt_idx) + 1);
            // Writes to x0 are consumed without touching the port
            if (sel_rd != '0) begin
                wb_en_d   = 1'b1;
                wb_addr_d = sel_rd;
                wb_data_d = sel_data;
            end
        end

        // Clear first so a same-cycle issue to the same register wins
        if (wb_en_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end
        if (iss_go && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any pending write and clears the scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_22040125_wb_sched.sv
// Bench for the writeback scheduler: directed scenarios followed by random
// traffic, all compared against a behavioural model of arbitration, the
// delayed write port and the busy scoreboard.
module tb_ysyx_22040125_wb_sched;

    localparam int NREQ = 3;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd, iss_rs1, iss_rs2;
    logic                 iss_hazard;
    logic [31:0]          busy_vec;

    ysyx_22040125_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_hazard (iss_hazard),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_ptr;
    bit          m_busy[32];
    bit          m_en;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    // requester-side state
    bit          rv[3];
    logic [4:0]  rrd[3];
    logic [63:0] rdat[3];

    logic [2:0]  obs_ready;
    logic        obs_haz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    endtask

    function automatic bit sb(input logic [4:0] x);
        return m_busy[x] && !(m_en && (m_addr == x));
    endfunction

    task automatic apply();
        for (int i = 0; i < 3; i++) begin
            req_valid[i]          = rv[i];
            req_rd[i*5 +: 5]      = rrd[i];
            req_data[i*64 +: 64]  = rdat[i];
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at
    // the edge, then check registered outputs just after it.
    task automatic cyc();
        int          g;
        int          j;
        logic [2:0]  er;
        logic        eh;
        bit          nb[32];
        logic [31:0] mb;
        apply();
        @(negedge clk);
        g = -1;
        for (int k = 0; k < 3; k++) begin
            j = (m_ptr + k) % 3;
            if (g < 0 && rv[j]) g = j;
        end
        er = (g < 0) ? 3'b000 : 3'(1 << g);
        eh = iss_valid && (sb(iss_rs1) || sb(iss_rs2) || sb(iss_rd));
        obs_ready = req_ready;
        obs_haz   = iss_hazard;
        chk("req_ready", {61'd0, req_ready}, {61'd0, er});
        chk("iss_hazard", {63'd0, iss_hazard}, {63'd0, eh});
        @(posedge clk);
        nb = m_busy;
        if (m_en) nb[m_addr] = 1'b0;
        if (iss_valid && !eh && iss_rd != 0) nb[iss_rd] = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_ptr = (g + 1) % 3;
            m_en  = (rrd[g] != 0);
            if (m_en) begin
                m_addr = rrd[g];
                m_data = rdat[g];
            end
            rv[g] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        #1;
        chk("wb_en", {63'd0, wb_en}, {63'd0, m_en});
        if (m_en) begin
            chk("wb_addr", {59'd0, wb_addr}, {59'd0, m_addr});
            chk("wb_data", wb_data, m_data);
        end
        for (int r = 0; r < 32; r++) mb[r] = m_busy[r];
        chk("busy_vec", {32'd0, busy_vec}, {32'd0, mb});
    endtask

    task automatic iss(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v;
        iss_rd    = rd;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
    endtask

    initial begin
        bit got;
        rst_n = 1'b0;
        iss(1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            rv[i]   = 1'b1;
            rrd[i]  = 5'(i + 1);
            rdat[i] = 64'(i + 100);
        end
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_busy", {32'd0, busy_vec}, 64'd0);
        chk("rst_ready", {61'd0, req_ready}, 64'd0);
        rst_n = 1'b1;

        // all three valid for six cycles: grants rotate 0,1,2,0,1,2
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("rotate_gnt", {61'd0, obs_ready}, 64'(1 << (c % 3)));
            for (int i = 0; i < 3; i++) begin
                if (!rv[i] && c < 3) begin
                    rv[i]   = 1'b1;
                    rrd[i]  = 5'(10 + i);
                    rdat[i] = 64'h1000 + 64'(c * 16 + i);
                end
            end
        end
        cyc();

        // single ALU write, then a write to x0
        rv[0] = 1'b1; rrd[0] = 5'd5; rdat[0] = 64'hDEAD_BEEF;
        cyc();
        chk("alu_ready", {61'd0, obs_ready}, 64'b001);
        chk("alu_wb_en", {63'd0, wb_en}, 64'd1);
        chk("alu_wb_addr", {59'd0, wb_addr}, 64'd5);
        chk("alu_wb_data", wb_data, 64'hDEAD_BEEF);
        rv[0] = 1'b1; rrd[0] = 5'd0; rdat[0] = 64'h1234;
        cyc();
        chk("x0_ready", {61'd0, obs_ready}, 64'd1 << (m_ptr == 1 ? 0 : 0));
        chk("x0_wb_en", {63'd0, wb_en}, 64'd0);

        // RAW on x7 released in the cycle its writeback is on the port
        iss(1'b1, 5'd7, 5'd0, 5'd0);
        cyc();
        chk("raw_busy7", {63'd0, busy_vec[7]}, 64'd1);
        iss(1'b1, 5'd0, 5'd7, 5'd0);
        rv[0] = 1'b1; rrd[0] = 5'd7; rdat[0] = 64'h77;
        cyc();
        chk("raw_stall", {63'd0, obs_haz}, 64'd1);
        cyc();
        chk("raw_fwd", {63'd0, obs_haz}, 64'd0);
        chk("raw_clear7", {63'd0, busy_vec[7]}, 64'd0);

        // WAW on x9: issue in the write cycle keeps the bit set
        iss(1'b1, 5'd9, 5'd0, 5'd0);
        cyc();
        iss(1'b0, 5'd0, 5'd0, 5'd0);
        rv[0] = 1'b1; rrd[0] = 5'd9; rdat[0] = 64'h99;
        cyc();
        iss(1'b1, 5'd9, 5'd0, 5'd0);
        cyc();
        chk("waw_nostall", {63'd0, obs_haz}, 64'd0);
        chk("waw_setwins", {63'd0, busy_vec[9]}, 64'd1);

        // fill the scoreboard; x0 sources never stall
        for (int r = 1; r < 32; r++) begin
            iss(1'b1, 5'(r), 5'd0, 5'd0);
            cyc();
        end
        chk("busy_full", {32'd0, busy_vec}, 64'hFFFF_FFFE);
        iss(1'b1, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("x0_nohaz", {63'd0, obs_haz}, 64'd0);
        iss(1'b1, 5'd0, 5'd3, 5'd0);
        cyc();
        chk("rs1_haz", {63'd0, obs_haz}, 64'd1);
        iss(1'b0, 5'd0, 5'd3, 5'd0);
        cyc();
        chk("novalid_nohaz", {63'd0, obs_haz}, 64'd0);

        // MDU held against a permanently valid LSU
        rv[1] = 1'b1; rrd[1] = 5'd20; rdat[1] = 64'h2020;
        got = 1'b0;
        for (int c = 0; c < 2 && !got; c++) begin
            if (!rv[2]) begin
                rv[2] = 1'b1; rrd[2] = 5'(21 + c); rdat[2] = 64'(c);
            end
            cyc();
            if (obs_ready[1]) got = 1'b1;
        end
        chk("mdu_nostarve", {63'd0, got}, 64'd1);
        rv[2] = 1'b0;
        cyc();

        // reset in the middle of a write
        rv[0] = 1'b1; rrd[0] = 5'd3; rdat[0] = 64'h33;
        iss(1'b1, 5'd12, 5'd0, 5'd0);
        cyc();
        iss(1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b1; rrd[i] = 5'(24 + i); rdat[i] = 64'(i);
        end
        apply();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("midrst_busy", {32'd0, busy_vec}, 64'd0);
        chk("midrst_ready", {61'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_ready2", {61'd0, req_ready}, 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_gnt", {61'd0, obs_ready}, 64'b001);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i]   = 1'b1;
                    rrd[i]  = 5'($urandom_range(0, 7));
                    rdat[i] = {$urandom, $urandom};
                end
            end
            iss(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
